// File: rtl/wrr_pkg.sv
// Shared definitions for the weighted round-robin grant scheduler and its picker.
package wrr_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   // Extracts requester idx's weight from a packed weight vector.
   function automatic logic [W_DEF-1:0] weight_of(input logic [N_DEF*W_DEF-1:0] packed_w,
                                                  input int idx);
      return packed_w[idx*W_DEF +: W_DEF];
   endfunction

endpackage

// File: rtl/wrr_grant_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set bit of eligible at or after ptr, with wrap.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] winner,
   output logic          found
);

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (eligible[(int'(ptr) + k) % N]) begin
            winner = IW'((int'(ptr) + k) % N);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin scheduler: a grantee keeps the grant for up to weight
// back-to-back transactions (ended by release_txn pulses), then the grant rotates.
module wrr_grant_scheduler
   import wrr_pkg::*;
#(
   parameter int N            = N_DEF,
   parameter int W            = W_DEF,
   parameter int RESET_WEIGHT = 1,
   localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   request,
   input  logic [N*W-1:0] weights,
   input  logic           weights_load,
   input  logic           release_txn,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IW-1:0]  grant_id,
   output logic [W-1:0]   credit,
   output logic           dbg_state
);

   // Handshake: grant is a registered level; the grantee owns the resource until
   // it pulses release_txn for one cycle, which closes exactly one transaction.

   state_t        state, state_n;
   logic [N-1:0]  grant_n, eligible;
   logic [IW-1:0] ptr, ptr_n, pick_ptr, gid_n, winner, next_id;
   logic [W-1:0]  credit_n;
   logic [W-1:0]  wreg [N];
   logic          found;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N; i++) eligible[i] = request[i] && (wreg[i] != '0);
   end

   assign next_id = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .eligible (eligible),
      .ptr      (pick_ptr),
      .winner   (winner),
      .found    (found)
   );

   // While granted, the search starts just past the grantee, so the old grantee
   // only wins again when it is the sole eligible requester.
   always_comb begin
      state_n  = state;
      grant_n  = grant;
      gid_n    = grant_id;
      credit_n = credit;
      ptr_n    = ptr;
      pick_ptr = ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_n  = GRANTED;
               grant_n  = N'(1) << winner;
               gid_n    = winner;
               credit_n = wreg[winner];
            end
         end
         GRANTED: begin
            pick_ptr = next_id;
            if (release_txn) begin
               if (credit > W'(1) && request[grant_id]) begin
                  credit_n = credit - W'(1);
               end else begin
                  ptr_n = next_id;
                  if (found) begin
                     grant_n  = N'(1) << winner;
                     gid_n    = winner;
                     credit_n = wreg[winner];
                  end else begin
                     state_n  = IDLE;
                     grant_n  = '0;
                     gid_n    = '0;
                     credit_n = '0;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         credit   <= '0;
         ptr      <= '0;
         for (int i = 0; i < N; i++) wreg[i] <= W'(RESET_WEIGHT);
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         grant_id <= gid_n;
         credit   <= credit_n;
         ptr      <= ptr_n;
         // Credit loads above read the old register value on this same edge.
         if (weights_load) begin
            for (int i = 0; i < N; i++) wreg[i] <= weight_of(weights, i);
         end
      end
   end

   assign grant_valid = |grant;
   assign dbg_state   = (state == GRANTED);

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Bench for wrr_grant_scheduler: hand-derived vector table, async-reset sequences,
// then random traffic against a transaction-level reference model.
module tb_wrr_grant_scheduler;
   import wrr_pkg::*;

   localparam int N = 4;
   localparam int W = 4;

   typedef struct {
      logic [N-1:0]   req;
      logic           rel;
      logic           ld;
      logic [N*W-1:0] wts;
      logic [N-1:0]   g;
      logic [W-1:0]   c;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   request;
   logic [N*W-1:0] weights;
   logic           weights_load;
   logic           release_txn;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [1:0]     grant_id;
   logic [W-1:0]   credit;
   logic           dbg_state;

   int vec_count   = 0;
   int miscompares = 0;

   logic [N+W-1:0] exp_q[$];
   vec_t           tbl[$];

   // reference model state: owner -1 means nobody holds the grant
   int m_owner, m_credit, m_ptr;
   int m_w [N];

   wrr_grant_scheduler #(.N(N), .W(W), .RESET_WEIGHT(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .request      (request),
      .weights      (weights),
      .weights_load (weights_load),
      .release_txn  (release_txn),
      .grant        (grant),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id),
      .credit       (credit),
      .dbg_state    (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [N-1:0] req, input logic rel, input logic ld,
                               input logic [N*W-1:0] wts, input logic [N-1:0] g,
                               input logic [W-1:0] c);
      vec_t v;
      v.req = req; v.rel = rel; v.ld = ld; v.wts = wts; v.g = g; v.c = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [N-1:0] eg, input logic [W-1:0] ec);
      logic [1:0] eid;
      eid = '0;
      for (int i = 0; i < N; i++) if (eg[i]) eid = 2'(i);
      vec_count++;
      if (grant !== eg || grant_id !== eid || grant_valid !== (|eg) || credit !== ec ||
          dbg_state !== (|eg)) begin
         miscompares++;
         $display("FAIL %s @%0t: got grant=%b id=%0d valid=%b credit=%0d busy=%b, want grant=%b id=%0d valid=%b credit=%0d",
                  name, $time, grant, grant_id, grant_valid, credit, dbg_state,
                  eg, eid, |eg, ec);
      end
   endtask

   // driver: apply inputs for one cycle, return #1 after the capturing edge
   task automatic drive(input logic [N-1:0] r, input logic rl, input logic ld,
                        input logic [N*W-1:0] w);
      request = r; release_txn = rl; weights_load = ld; weights = w;
      @(posedge clk);
      #1;
   endtask

   function automatic int m_search(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N] && m_w[(start + k) % N] != 0) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_owner = -1; m_credit = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_w[i] = 1;
   endtask

   // one transaction-level step of the scheduling rules
   task automatic m_step(input logic [N-1:0] r, input logic rl, input logic ld,
                         input logic [N*W-1:0] w);
      int cand;
      if (m_owner < 0) begin
         cand = m_search(r, m_ptr);
         if (cand >= 0) begin m_owner = cand; m_credit = m_w[cand]; end
      end else if (rl) begin
         if (m_credit > 1 && r[m_owner]) begin
            m_credit = m_credit - 1;
         end else begin
            m_ptr   = (m_owner + 1) % N;
            cand    = m_search(r, m_ptr);
            m_owner = cand;
            m_credit = (cand >= 0) ? m_w[cand] : 0;
         end
      end
      if (ld) for (int i = 0; i < N; i++) m_w[i] = int'(w[i*W +: W]);
   endtask

   initial begin
      logic [N+W-1:0] e;
      logic [N-1:0]   r;
      logic           rl, ld;
      logic [N*W-1:0] w;

      reset = 1'b1; request = '0; weights = '0; weights_load = 1'b0; release_txn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 4'b0000, 4'd0);
      reset = 1'b0;

      // weights all 1, request 1011, release every third cycle
      for (int k = 0; k < 15; k++) begin
         logic [N-1:0] gs [3];
         gs[0] = 4'b0001; gs[1] = 4'b0010; gs[2] = 4'b1000;
         tbl.push_back(mk(4'b1011, (k % 3) == 2, 1'b0, 16'h0,
                          gs[((k + 1) / 3) % 3], 4'd1));
      end
      // w0=3, w1=0: requester 1 masked, requester 0 bursts 3,2,1 and is re-granted
      tbl.push_back(mk(4'b0011, 1'b0, 1'b1, 16'h0003, 4'b1000, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0003, 4'b0001, 4'd3));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0003, 4'b0001, 4'd2));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0003, 4'b0001, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0003, 4'b0001, 4'd3));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0003, 4'b0001, 4'd2));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0003, 4'b0001, 4'd1));
      // w0=2, w1=1, release every cycle: 1,0,0,1,0,0,1 with no idle gap
      tbl.push_back(mk(4'b0011, 1'b0, 1'b1, 16'h0012, 4'b0001, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0010, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0001, 4'd2));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0001, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0010, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0001, 4'd2));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0001, 4'd1));
      tbl.push_back(mk(4'b0011, 1'b1, 1'b0, 16'h0012, 4'b0010, 4'd1));
      // w0=3, w2=2: grantee 0 drops request in its release cycle, grant moves to 2
      tbl.push_back(mk(4'b0101, 1'b0, 1'b1, 16'h0203, 4'b0010, 4'd1));
      tbl.push_back(mk(4'b0001, 1'b1, 1'b0, 16'h0203, 4'b0001, 4'd3));
      tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 16'h0203, 4'b0100, 4'd2));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 16'h0203, 4'b0100, 4'd2));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 16'h0203, 4'b0000, 4'd0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 16'h0203, 4'b0000, 4'd0));
      // w0 reloaded 3 -> 1 mid-burst: burst still runs 3, next burst gets 1
      tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 16'h0203, 4'b0001, 4'd3));
      tbl.push_back(mk(4'b0001, 1'b1, 1'b1, 16'h0201, 4'b0001, 4'd2));
      tbl.push_back(mk(4'b0001, 1'b1, 1'b0, 16'h0201, 4'b0001, 4'd1));
      tbl.push_back(mk(4'b0001, 1'b1, 1'b0, 16'h0201, 4'b0001, 4'd1));
      // weight 0 loaded for the grantee: held until its release, then idle
      tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 16'h0200, 4'b0001, 4'd1));
      tbl.push_back(mk(4'b0001, 1'b1, 1'b0, 16'h0200, 4'b0000, 4'd0));
      // load coincident with a credit load uses the old weight (2, not 5)
      tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 16'h0500, 4'b0100, 4'd2));
      tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 16'h0500, 4'b0100, 4'd1));
      tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 16'h0500, 4'b0100, 4'd5));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].req, tbl[i].rel, tbl[i].ld, tbl[i].wts);
         check($sformatf("table[%0d]", i), tbl[i].g, tbl[i].c);
      end

      // asynchronous reset while grant=0100 clears outputs before the next edge
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_clear", 4'b0000, 4'd0);
      @(posedge clk);
      #1;
      check("reset_held", 4'b0000, 4'd0);
      reset = 1'b0;
      drive(4'b0100, 1'b0, 1'b0, '0);
      check("regrant_after_reset", 4'b0100, 4'd1);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      drive(4'b1111, 1'b0, 1'b0, '0);
      check("ptr_restart", 4'b0001, 4'd1);

      // random traffic against the reference model
      reset = 1'b1;
      #2;
      reset = 1'b0;
      m_reset();
      for (int k = 0; k < 600; k++) begin
         r  = 4'($urandom_range(0, 15));
         rl = 1'($urandom_range(0, 1));
         ld = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < N; i++) w[i*W +: W] = 4'($urandom_range(0, 3));
         m_step(r, rl, ld, w);
         exp_q.push_back({(m_owner < 0) ? 4'b0000 : 4'(1 << m_owner), 4'(m_credit)});
         drive(r, rl, ld, w);
         e = exp_q.pop_front();
         check($sformatf("random[%0d]", k), e[N+W-1:W], e[W-1:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/wrr_grant_scheduler.md
Name: wrr_grant_scheduler

Overview:
- Transaction-level weighted round-robin scheduler that shares one downstream resource among N requesters.
- Each winner holds a one-hot grant until it signals release. It keeps ownership for up to weight consecutive transactions while it is still requesting, then the grant rotates.
- Weights are held in an internal register loaded by a strobe, so software reconfiguration does not disturb an in-flight burst.
- Sits between requester masters and the shared resource mux.

Parameters:
- N, 4, number of requesters.
- W, 4, weight/credit width per requester.
- RESET_WEIGHT, 1, per-requester weight after reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- request  input  N  per-requester request level.
- weights  input  N*W  packed weights; requester i uses bits [i*W +: W].
- weights_load  input  1  when high, latches weights into the weight register.
- release  input  1  one-cycle pulse from the current grantee marking end of one transaction.
- grant  output  N  one-hot grant, registered.
- grant_valid  output  1  high whenever grant is non-zero.
- grant_id  output  clog2(N)  index of the current grantee; 0 when idle.
- credit  output  W  transactions the grantee has left in its burst, including the current one.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, credit=0.
  - RR pointer=0, state=IDLE.
  - Every weight register field = RESET_WEIGHT.
- Eligibility: requester i is eligible when request[i]=1 and its registered weight != 0. A weight of 0 masks the requester completely.
- Arbitration:
  - Search starts at the RR pointer and proceeds in increasing index with wrap-around.
  - The first eligible requester wins.
- FSM state IDLE:
  - Entry: after reset, or after release when no requester is eligible.
  - If any requester is eligible, the next cycle has grant=onehot(winner), grant_valid=1, credit=weight[winner], and state=GRANTED.
  - Latency from request rise to grant is 1 cycle.
- FSM state GRANTED:
  - Grant is held stable until release=1. request is ignored except in the release cycle; dropping request without release does not end the grant.
  - On release with credit>1 and request[grantee]=1: grant unchanged, credit decrements by 1. Back-to-back transactions have no gap.
  - Otherwise on release (burst exhausted, or grantee no longer requesting):
    - RR pointer = (grantee+1) mod N.
    - Re-arbitrate in the same cycle, excluding the old grantee unless it is the only eligible requester.
    - If there is a winner, the grant switches to it on the next cycle with no idle cycle, and credit = winner's weight.
    - If there is no winner, go to IDLE with grant=0.
- release while in IDLE is ignored.
- weights_load:
  - Updates the weight register on the next edge.
  - Does not change the credit of a burst already in progress.
  - A weight value latched in the same cycle as a credit load is NOT used for that load; the load uses the old register value.
  - Loading 0 for the current grantee does not revoke the grant; the burst ends at its next release.
- Asynchronous reset mid-burst clears grant immediately (combinationally via flop reset) and restores all reset values. The pointer returns to 0.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - credit >= 1 whenever grant_valid=1.

Decomposition:
- Shared package wrr_pkg holds:
  - N and W defaults.
  - The state enum (IDLE, GRANTED).
  - Function weight_of(packed, idx).
- One sub-module, rr_pick: combinational rotating priority picker. Inputs: eligible mask, pointer. Outputs: winner index, found flag. It is reused by the other arbiters in the codebase.

Test Plan:
- Reset, all weights 1, request=4'b1011 held, release pulsed every 3 cycles -> grant_id sequence 0,1,3,0,1,3; grant one-hot; credit=1 at each grant.
- weights=16'h0003 (w0=3, others 0) with weights_load, request=4'b0011 -> requester 0 gets 3 back-to-back transactions with credit 3,2,1; requester 1 (weight 0) is never granted; requester 0 is re-granted after an unbroken 3-cycle rotation check.
- weights=16'h0012 (w0=2, w1=1), request=4'b0011, release every cycle -> grant pattern 0,0,1,0,0,1 with no idle cycle between owners.
- Grantee 0 with credit 3 drops request in the release cycle -> grant moves to next eligible (index 2 if request=4'b0101); credit reloads to w2.
- weights_load of new weights mid-burst (w0 from 3 to 1 after first release) -> current burst still completes 3 transactions; next burst for requester 0 gets credit 1.
- reset asserted asynchronously while grant=4'b0100 -> grant=0 before the next clock edge; after deassertion with request=4'b0100, grant returns one cycle later with credit=RESET_WEIGHT and pointer-based order restarting at 0.
